mem_port_arbiter: RTL

// Shares the single physical memory port between the instruction-fetch requester
// (fetch states of the control FSM) and the data requester (LDR/STR load/store states).

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the instruction-fetch and data requesters.
// Grant is held in registered state; a watchdog aborts grants that never complete.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FAIR    = 1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_wmask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [1:0]        pmem_wmask,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          d_req;
  logic          wd_expire;

  assign d_req     = d_read | d_write;
  assign wd_expire = (TIMEOUT != 0) && (timer_q == TMAX);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    timer_d  = timer_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (i_read && d_req)
          state_d = ((FAIR != 0) && last_d_q) ? GNT_I : GNT_D;
        else if (i_read)
          state_d = GNT_I;
        else if (d_req)
          state_d = GNT_D;
      end
      GNT_I: begin
        // Order matters: a dropped request beats resp, resp beats the watchdog.
        if (!i_read) begin
          state_d = IDLE;
        end else if (pmem_resp) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end else if (wd_expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GNT_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else if (pmem_resp) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end else if (wd_expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // Strobes follow the granted requester's level so a dropped request releases memory at once.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    pmem_wmask = 2'b11;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state_q)
      GNT_I: begin
        pmem_read = i_read;
        pmem_addr = i_addr;
        i_resp    = i_read & pmem_resp;
      end
      GNT_D: begin
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        pmem_wmask = d_wmask;
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        d_resp     = d_req & pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata     = pmem_rdata;
  assign d_rdata     = pmem_rdata;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule
